// File: rtl/moving_avg_pkg.sv
// Shared types and default sizing for the moving-average sample path.
package moving_avg_pkg;

   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned TX_DEPTH = 4;
   localparam int unsigned TX_GAP   = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STB  = 2'd1,
      GAP  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full even if a pop coincides.
module sample_fifo
   import moving_avg_pkg::*;
#(
   parameter int unsigned DATA_W = SAMPLE_W,
   parameter int unsigned DEPTH  = TX_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push_en;
   logic              pop_en;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage carries no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_en, pop_en})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/sample_strobe_tx.sv
// Replays buffered samples as single-cycle strobes with a programmable low gap between them.
module sample_strobe_tx #(
   parameter int unsigned DATA_W = moving_avg_pkg::SAMPLE_W,
   parameter int unsigned DEPTH  = moving_avg_pkg::TX_DEPTH,
   parameter int unsigned GAP    = moving_avg_pkg::TX_GAP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          stb_data,
   output logic                       stb,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   import moving_avg_pkg::*;

   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   tx_state_t         state;
   logic [GAP_W-1:0]  gap_cnt;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              empty;
   logic              launch;

   sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid),
      .wr_data (in_data),
      .pop     (launch),
      .rd_data (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   // A new strobe may start from IDLE or at the end of the final gap cycle.
   assign launch = ena && !empty &&
                   ((state == IDLE) ||
                    ((state == moving_avg_pkg::GAP) && (gap_cnt == '0)));

   assign in_ready = !full;
   assign busy     = (state != IDLE) || !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gap_cnt  <= '0;
         stb      <= 1'b0;
         stb_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  state    <= STB;
                  stb      <= 1'b1;
                  stb_data <= head;
               end
            end
            STB: begin
               state   <= moving_avg_pkg::GAP;
               stb     <= 1'b0;
               gap_cnt <= GAP_W'(GAP - 1);
            end
            moving_avg_pkg::GAP: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end else if (launch) begin
                  state    <= STB;
                  stb      <= 1'b1;
                  stb_data <= head;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               stb   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_strobe_tx.sv
// Directed bench for sample_strobe_tx with default sizing (8-bit, depth 4, gap 1).
module tb_sample_strobe_tx;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] stb_data;
   logic       stb;
   logic       busy;
   logic [2:0] level;

   int         n_assert;
   int         n_fail;
   logic [7:0] got [$];

   sample_strobe_tx dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .stb_data (stb_data),
      .stb      (stb),
      .busy     (busy),
      .level    (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every strobed sample, mid-cycle.
   always @(negedge clk) begin
      if (!rst && stb) got.push_back(stb_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_got(input string tag, input logic [7:0] exp []);
      chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < got.size()) chk($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      logic [7:0] exp [];
      logic [7:0] pat;
      logic       acc;
      int         idx;
      int         cyc;
      logic       stb_exp [10];

      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      ena      = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      #12;
      chk("rst_stb", 32'(stb), 32'h0);
      chk("rst_stb_data", 32'(stb_data), 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Single sample: strobe one cycle after acceptance.
      got.delete();
      ena = 1'b1; in_data = 8'h01; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_level_after_push", 32'(level), 32'h1);
      chk("single_stb_not_yet", 32'(stb), 32'h0);
      tick();
      chk("single_stb", 32'(stb), 32'h1);
      chk("single_stb_data", 32'(stb_data), 32'h01);
      chk("single_busy_stb", 32'(busy), 32'h1);
      tick();
      chk("single_stb_low", 32'(stb), 32'h0);
      chk("single_busy_gap", 32'(busy), 32'h1);
      tick();
      chk("single_busy_idle", 32'(busy), 32'h0);
      chk("single_data_hold", 32'(stb_data), 32'h01);
      exp = '{8'h01};
      chk_got("single_seq", exp);

      // Burst of four at gap 1: strobe toggles every cycle.
      got.delete();
      stb_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin
            chk($sformatf("burst_ready_%0d", i), 32'(in_ready), 32'h1);
            in_data = 8'(i + 1); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         chk($sformatf("burst_stb_%0d", i), 32'(stb), 32'(stb_exp[i]));
      end
      exp = '{8'h01, 8'h02, 8'h03, 8'h04};
      chk_got("burst_seq", exp);

      // Backpressure: fill with ena low, fifth sample stalls.
      got.delete();
      ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'(8'h10 + i); in_valid = 1'b1;
         tick();
      end
      chk("full_level", 32'(level), 32'h4);
      chk("full_in_ready", 32'(in_ready), 32'h0);
      in_data = 8'h14;
      tick();
      chk("full_stalled_level", 32'(level), 32'h4);
      chk("full_no_strobe", 32'(stb), 32'h0);
      ena = 1'b1;
      tick();
      chk("full_first_stb", 32'(stb), 32'h1);
      chk("full_level_after_pop", 32'(level), 32'h3);
      chk("full_ready_after_pop", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("full_level_refill", 32'(level), 32'h4);
      for (int i = 0; i < 12; i++) tick();
      exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      chk_got("full_seq", exp);
      chk("full_drained", 32'(busy), 32'h0);

      // Enable drop during the second strobe.
      got.delete();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'h20 + i); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      ena = 1'b1;
      tick();
      tick();
      tick();
      chk("drop_second_stb", 32'(stb), 32'h1);
      chk("drop_second_data", 32'(stb_data), 32'h21);
      ena = 1'b0;
      tick();
      chk("drop_gap_stb", 32'(stb), 32'h0);
      tick();
      chk("drop_level", 32'(level), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("drop_hold_stb_%0d", i), 32'(stb), 32'h0);
      end
      chk("drop_held_level", 32'(level), 32'h1);
      ena = 1'b1;
      tick();
      chk("drop_third_stb", 32'(stb), 32'h1);
      chk("drop_third_data", 32'(stb_data), 32'h22);
      chk("drop_level_empty", 32'(level), 32'h0);
      tick();
      tick();
      exp = '{8'h20, 8'h21, 8'h22};
      chk_got("drop_seq", exp);

      // Wrap-around: 12 samples streamed under backpressure.
      got.delete();
      exp = new[12];
      for (int i = 0; i < 12; i++) exp[i] = 8'((i + 2) % 5);
      idx = 0;
      cyc = 0;
      while ((idx < 12 || got.size() < 12) && cyc < 200) begin
         if (idx < 12) begin
            pat = exp[idx];
            in_data = pat; in_valid = 1'b1;
            acc = in_ready;
         end else begin
            in_valid = 1'b0;
            acc = 1'b0;
         end
         tick();
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      chk("wrap_within_budget", 32'(cyc < 200), 32'h1);
      tick();
      tick();
      chk_got("wrap_seq", exp);

      // Asynchronous reset with samples queued and a strobe in flight.
      got.delete();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'h30 + i); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      ena = 1'b1;
      tick();
      chk("rstmid_pre_stb", 32'(stb), 32'h1);
      #3 rst = 1'b1;
      #1;
      chk("rstmid_stb", 32'(stb), 32'h0);
      chk("rstmid_stb_data", 32'(stb_data), 32'h0);
      chk("rstmid_level", 32'(level), 32'h0);
      chk("rstmid_in_ready", 32'(in_ready), 32'h1);
      chk("rstmid_busy", 32'(busy), 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;
      got.delete();
      for (int i = 0; i < 6; i++) tick();
      chk("rstmid_no_strobe", 32'(got.size()), 32'h0);
      chk("rstmid_level_after", 32'(level), 32'h0);
      in_data = 8'h55; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      exp = '{8'h55};
      chk_got("rstmid_new_seq", exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_strobe_tx.md
# sample_strobe_tx

Transmit side of the averager's strobed-sample input interface. Accepts samples from an upstream source over a valid/ready handshake and buffers them in a small FIFO. Replays them onto an 8-bit data bus with a one-cycle strobe per sample, enforcing a programmable idle gap between strobes. It sits directly in front of `tt_um_moving_average`: `stb_data` drives `ui_in`, `stb` drives `uio_in[0]`.

## Interface
- `DATA_W`, 8, sample width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `GAP`, 1, strobe-low cycles between consecutive strobes; ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ena`  in  1  launch enable; low blocks new strobes.
- `in_data`  in  DATA_W  upstream sample.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  FIFO can accept.
- `stb_data`  out  DATA_W  sample presented to the averager.
- `stb`  out  1  one-cycle sample strobe.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Push: on the rising edge when `in_valid && in_ready`, write `in_data` at the write pointer.
  - `in_ready = (level != DEPTH)`, decoded from registers only.
  - No push at full, even if a pop occurs in the same cycle.
- FSM states: IDLE, STB, GAP.
  - IDLE → STB when `level>0 && ena`. On that edge: pop the head into the `stb_data` register and set `stb`=1.
  - STB → GAP unconditionally, after exactly one cycle. `stb` returns to 0 and `gap_cnt` loads GAP-1.
  - GAP counts down. On the edge leaving the last gap cycle (`gap_cnt==0`):
    - go to STB with a pop if `level>0 && ena`;
    - otherwise go to IDLE.
- `stb_data` holds its last value through GAP and IDLE, and changes only on a pop.
- `ena` deasserted during STB or GAP: the current strobe and gap complete, then the FSM goes to IDLE. No sample is lost.
- Simultaneous push and pop with `level` in 1..DEPTH-1: `level` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Ordering is strictly FIFO.
- Data passes through unmodified. No arithmetic on samples.

## Timing
- Values in reset (asynchronous, held while `rst`=1), with FIFO contents discarded:
  - `stb`=0, `stb_data`=0, `level`=0;
  - `in_ready`=1, `busy`=0;
  - state IDLE, pointers 0, `gap_cnt`=0.
- Reset asserted mid-burst: outputs take their reset values immediately and no partial strobe completes.
- Latency: a sample accepted at edge k into an empty FIFO, with `ena`=1, gives `stb`=1 in the cycle after edge k+1.
- Back-to-back strobe period is 1+GAP cycles. With GAP=1, `stb` toggles 1,0,1,0 — one sample every 2 cycles.
- `level` updates at the edge of the push or pop.
- `in_ready` rises the cycle after the pop that frees an entry.

## Structure
- Shared package `moving_avg_pkg`:
  - state enum `tx_state_t` {IDLE, STB, GAP};
  - default constants `SAMPLE_W`=8, `TX_DEPTH`=4, `TX_GAP`=1.
- Sub-module `sample_fifo`: synchronous single-clock FIFO with push/pop, level, full/empty, parameterised on DATA_W/DEPTH.
- Top module: FSM and gap counter only.

## Test plan
- Single sample:
  - stimulus: after reset, push 0x01 with `ena`=1;
  - required: `stb`=1 for exactly one cycle, starting 1 cycle after acceptance; `stb_data`=0x01 from then on; `busy`=0 once GAP ends.
- Burst, GAP=1, `ena`=1:
  - stimulus: push 0x01,0x02,0x03,0x04 on consecutive cycles;
  - required: `stb` pattern 1,0,1,0,1,0,1,0 with `stb_data` 01,02,03,04; `in_ready` never drops.
- Full / backpressure:
  - stimulus: hold `ena`=0 and offer 5 samples 0x10..0x14;
  - required: `level`=4 and `in_ready`=0 after 4 pushes, with 0x14 stalled; then `ena`=1 gives strobes 10,11,12,13,14 in order.
- Enable drop:
  - stimulus: deassert `ena` during the STB cycle of the 2nd of 3 queued samples;
  - required: that strobe completes, the FSM enters IDLE after GAP, `level`=1, and the 3rd sample strobes only after `ena`=1.
- Wrap-around:
  - stimulus: stream 12 samples of the pattern 02,03,04,00,01,…;
  - required: the strobed sequence is identical and in order, with no duplicate or dropped samples.
- Reset mid-operation:
  - stimulus: assert `rst` asynchronously (not edge-aligned) with 3 samples queued;
  - required: `stb`=0, `stb_data`=0 and `level`=0 immediately; no further strobes after release until a new push.
